// File: rtl/lvds_link_trainer_if.sv
// Link-trainer signal bundle between the NoC/bridge side and lvds_link_trainer.
// The trainer connects through the slave modport; the driving environment uses master.
interface lvds_link_trainer_if #(
  parameter int unsigned CNT_WIDTH = 8
);
  logic                 i_sync_complete;
  logic                 o_sync_generate;
  logic                 o_link_up;
  logic                 i_tx_req;
  logic                 o_tx_start;
  logic                 i_tx_done;
  logic                 o_tx_ack;
  logic                 o_tx_abort;
  logic [CNT_WIDTH-1:0] o_retrain_cnt;
  logic                 o_timeout;

  modport slave (
    input  i_sync_complete,
    input  i_tx_req,
    input  i_tx_done,
    output o_sync_generate,
    output o_link_up,
    output o_tx_start,
    output o_tx_ack,
    output o_tx_abort,
    output o_retrain_cnt,
    output o_timeout
  );

  modport master (
    output i_sync_complete,
    output i_tx_req,
    output i_tx_done,
    input  o_sync_generate,
    input  o_link_up,
    input  o_tx_start,
    input  o_tx_ack,
    input  o_tx_abort,
    input  o_retrain_cnt,
    input  o_timeout
  );
endinterface

// File: rtl/lvds_link_trainer.sv
// LVDS link bring-up sequencer and tx start gating. Optional TRAIN timeout is enabled by
// defining LINK_TRAINER_TIMEOUT_EN; without it TRAIN waits indefinitely and o_timeout is 0.
module lvds_link_trainer #(
  parameter int unsigned STARTUP_CYCLES = 64,
  parameter int unsigned HOLD_CYCLES    = 256,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input logic               i_clk,
  input logic               i_rst,
  lvds_link_trainer_if.slave link_io
);

  localparam int unsigned WaitW = $clog2(STARTUP_CYCLES + 1);
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {StWait, StTrain, StHold, StUp} state_e;

  state_e               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 sync_s;
  logic [WaitW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [HoldW-1:0]     hold_cnt_q, hold_cnt_d;
  logic                 busy_q, busy_d;
  logic [CNT_WIDTH-1:0] retrain_q, retrain_d;
  logic                 ack_q, ack_d;
  logic                 abort_q, abort_d;
  logic                 link_up_q, sync_gen_q;
  logic                 tx_start;

`ifdef LINK_TRAINER_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           timeout_q, timeout_d;
`endif

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    hold_cnt_d = hold_cnt_q;
    busy_d     = busy_q;
    retrain_d  = retrain_q;
    ack_d      = 1'b0;
    abort_d    = 1'b0;
    tx_start   = 1'b0;
`ifdef LINK_TRAINER_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
    timeout_d  = 1'b0;
`endif
    unique case (state_q)
      StWait: begin
        if (wait_cnt_q == WaitW'(STARTUP_CYCLES - 1)) begin
          state_d = StTrain;
`ifdef LINK_TRAINER_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      StTrain: begin
        if (sync_s) begin
          state_d    = StHold;
          hold_cnt_d = '0;
        end
`ifdef LINK_TRAINER_TIMEOUT_EN
        else if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
          state_d    = StWait;
          wait_cnt_d = '0;
          timeout_d  = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
`endif
      end
      StHold: begin
        // Partner lock is only trusted once sync_s stays high for the whole hold window
        if (!sync_s) begin
          state_d = StTrain;
`ifdef LINK_TRAINER_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end else if (hold_cnt_q == HoldW'(HOLD_CYCLES - 1)) begin
          state_d = StUp;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      StUp: begin
        if (!sync_s) begin
          // Loss of sync beats a coincident tx_done: the transfer is reported as aborted
          state_d = StTrain;
          busy_d  = 1'b0;
          abort_d = busy_q;
          if (retrain_q != '1) retrain_d = retrain_q + CNT_WIDTH'(1);
`ifdef LINK_TRAINER_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end else if (busy_q) begin
          if (link_io.i_tx_done) begin
            ack_d  = 1'b1;
            busy_d = 1'b0;
          end
        end else if (link_io.i_tx_req) begin
          tx_start = 1'b1;
          busy_d   = 1'b1;
        end
      end
      default: state_d = StWait;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StWait;
      sync_q     <= '0;
      wait_cnt_q <= '0;
      hold_cnt_q <= '0;
      busy_q     <= 1'b0;
      retrain_q  <= '0;
      ack_q      <= 1'b0;
      abort_q    <= 1'b0;
      link_up_q  <= 1'b0;
      sync_gen_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], link_io.i_sync_complete};
      wait_cnt_q <= wait_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      busy_q     <= busy_d;
      retrain_q  <= retrain_d;
      ack_q      <= ack_d;
      abort_q    <= abort_d;
      link_up_q  <= (state_d == StUp);
      sync_gen_q <= (state_d != StUp);
    end
  end

`ifdef LINK_TRAINER_TIMEOUT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign link_io.o_timeout = timeout_q;
`else
  assign link_io.o_timeout = 1'b0;
`endif

  assign link_io.o_sync_generate = sync_gen_q;
  assign link_io.o_link_up       = link_up_q;
  assign link_io.o_tx_start      = tx_start;
  assign link_io.o_tx_ack        = ack_q;
  assign link_io.o_tx_abort      = abort_q;
  assign link_io.o_retrain_cnt   = retrain_q;

endmodule

// File: tb/tb_lvds_link_trainer.sv
// Scoreboard bench for lvds_link_trainer: a phase/countdown reference model predicts every
// cycle's outputs into a queue; a monitor pops and compares against the DUT.
module tb_lvds_link_trainer;

  localparam int unsigned StartupCycles = 64;
  localparam int unsigned HoldCycles    = 24;
  localparam int unsigned TimeoutCycles = 1000;
  localparam int unsigned SyncStages    = 2;
  localparam int unsigned CntWidth      = 8;
  localparam int          CntMax        = (1 << CntWidth) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lvds_link_trainer_if #(.CNT_WIDTH(CntWidth)) link_if ();

  lvds_link_trainer #(
    .STARTUP_CYCLES(StartupCycles),
    .HOLD_CYCLES   (HoldCycles),
    .TIMEOUT_CYCLES(TimeoutCycles),
    .SYNC_STAGES   (SyncStages),
    .CNT_WIDTH     (CntWidth)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .link_io(link_if)
  );

  typedef struct packed {
    logic                start;
    logic                ack;
    logic                abort;
    logic                link_up;
    logic                sync_gen;
    logic                timeout;
    logic [CntWidth-1:0] retrain;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   start_seen = 1'b0;

  // ---------------- reference model ----------------
  typedef enum {MWait, MTrain, MHold, MUp} mphase_e;
  mphase_e ph;
  int      remain;
  int      m_retrain;
  bit      m_busy, m_ack, m_abort, m_to;
  bit      syncd[$];

  task automatic model_reset();
    ph        = MWait;
    remain    = StartupCycles;
    m_retrain = 0;
    m_busy    = 1'b0;
    m_ack     = 1'b0;
    m_abort   = 1'b0;
    m_to      = 1'b0;
    syncd.delete();
    for (int i = 0; i < SyncStages; i++) syncd.push_back(1'b0);
  endtask

  initial begin : model
    obs_t e;
    bit   seen;
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) begin
        model_reset();
        e = '{start: 1'b0, ack: 1'b0, abort: 1'b0, link_up: 1'b0, sync_gen: 1'b1,
              timeout: 1'b0, retrain: '0};
        exp_q.push_back(e);
      end else begin
        seen       = syncd[$];
        e.link_up  = (ph == MUp);
        e.sync_gen = (ph != MUp);
        e.start    = (ph == MUp) && seen && !m_busy && link_if.i_tx_req;
        e.ack      = m_ack;
        e.abort    = m_abort;
        e.timeout  = m_to;
        e.retrain  = CntWidth'(m_retrain);
        exp_q.push_back(e);
        // advance one clock
        m_ack   = 1'b0;
        m_abort = 1'b0;
        m_to    = 1'b0;
        case (ph)
          MWait: begin
            remain--;
            if (remain == 0) begin ph = MTrain; remain = TimeoutCycles; end
          end
          MTrain: begin
            if (seen) begin
              ph = MHold; remain = HoldCycles;
            end else begin
`ifdef LINK_TRAINER_TIMEOUT_EN
              remain--;
              if (remain == 0) begin m_to = 1'b1; ph = MWait; remain = StartupCycles; end
`endif
            end
          end
          MHold: begin
            if (!seen) begin
              ph = MTrain; remain = TimeoutCycles;
            end else begin
              remain--;
              if (remain == 0) ph = MUp;
            end
          end
          MUp: begin
            if (!seen) begin
              ph      = MTrain;
              remain  = TimeoutCycles;
              m_abort = m_busy;
              m_busy  = 1'b0;
              if (m_retrain < CntMax) m_retrain++;
            end else if (m_busy) begin
              if (link_if.i_tx_done) begin m_ack = 1'b1; m_busy = 1'b0; end
            end else if (link_if.i_tx_req) begin
              m_busy = 1'b1;
            end
          end
          default: ph = MWait;
        endcase
        syncd.push_front(link_if.i_sync_complete);
        void'(syncd.pop_back());
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    obs_t e, got;
    forever begin
      @(negedge clk);
      #2;
      got = '{start: link_if.o_tx_start, ack: link_if.o_tx_ack, abort: link_if.o_tx_abort,
              link_up: link_if.o_link_up, sync_gen: link_if.o_sync_generate,
              timeout: link_if.o_timeout, retrain: link_if.o_retrain_cnt};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t got=%h required an expected entry", $time, got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display({"FAIL outputs t=%0t got start=%b ack=%b abort=%b up=%b gen=%b to=%b cnt=%0d",
                    " required start=%b ack=%b abort=%b up=%b gen=%b to=%b cnt=%0d"},
                   $time, got.start, got.ack, got.abort, got.link_up, got.sync_gen,
                   got.timeout, got.retrain, e.start, e.ack, e.abort, e.link_up, e.sync_gen,
                   e.timeout, e.retrain);
        end
      end
      start_seen = link_if.o_tx_start;
    end
  end

  // ---------------- stimulus ----------------
  bit auto_done = 1'b0;
  int done_cnt  = 0;

  // Advance one cycle; in auto mode answer each start with tx_done five cycles later
  task automatic tick();
    @(posedge clk);
    #1;
    link_if.i_tx_done = 1'b0;
    if (auto_done) begin
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) link_if.i_tx_done = 1'b1;
      end
      if (start_seen) done_cnt = 4;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin : driver
    int low_left;
    rst                     = 1'b1;
    link_if.i_sync_complete = 1'b0;
    link_if.i_tx_req        = 1'b0;
    link_if.i_tx_done       = 1'b0;
    ticks(3);
    rst = 1'b0;

    // bring-up: partner sync appears at cycle 100
    ticks(100);
    link_if.i_sync_complete = 1'b1;
    ticks(HoldCycles + 10);

    // back-to-back transfers with done five cycles after each start
    auto_done        = 1'b1;
    link_if.i_tx_req = 1'b1;
    ticks(62);
    // sync loss while a transfer is in flight; its late done must be ignored
    link_if.i_sync_complete = 1'b0;
    ticks(5);
    link_if.i_sync_complete = 1'b1;
    ticks(HoldCycles + 20);
    auto_done = 1'b0;

    // randomized traffic with sporadic sync drops
    low_left = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      link_if.i_tx_req  = ($urandom_range(0, 3) != 0);
      link_if.i_tx_done = ($urandom_range(0, 4) == 0);
      if (low_left > 0) begin
        low_left--;
        link_if.i_sync_complete = 1'b0;
      end else begin
        link_if.i_sync_complete = 1'b1;
        if ($urandom_range(0, 59) == 0) low_left = $urandom_range(1, 8);
      end
    end

    // asynchronous reset in the middle of traffic
    rst = 1'b1;
    ticks(2);
    rst               = 1'b0;
    link_if.i_tx_done = 1'b0;
    link_if.i_tx_req  = 1'b0;

    // sync never arrives: TRAIN waits (or times out when the timeout is built in)
    link_if.i_sync_complete = 1'b0;
    ticks(2500);

    // repeated retrains until the counter saturates
    link_if.i_sync_complete = 1'b1;
    ticks(HoldCycles + 10);
    for (int i = 0; i < 300; i++) begin
      link_if.i_sync_complete = 1'b0;
      ticks(3);
      link_if.i_sync_complete = 1'b1;
      ticks(HoldCycles + 8);
    end

    @(negedge clk);
    #3;
    checks++;
    if (link_if.o_retrain_cnt !== CntWidth'(CntMax)) begin
      errors++;
      $display("FAIL retrain_saturation got=%0d required=%0d", link_if.o_retrain_cnt, CntMax);
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d pending required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
